// File: rtl/iob_axi_crossbar_arb.sv
// Registered request/grant arbiter for the AXI crossbar address and return channels.
// Grants one requester at a time. A grant is held while it is in use, and
// round-robin masking keeps the arbitration fair.
module iob_axi_crossbar_arb #(
    parameter int unsigned PORTS             = 4,
    parameter int unsigned ARB_ROUND_ROBIN   = 1,
    parameter int unsigned ARB_BLOCK         = 1,
    parameter int unsigned ARB_BLOCK_ACK     = 1,
    parameter int unsigned LSB_HIGH_PRIORITY = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS-1:0]           request,
    input  logic [PORTS-1:0]           acknowledge,
    output logic [PORTS-1:0]           grant,
    output logic                       grant_valid,
    output logic [$clog2(PORTS)-1:0]   grant_encoded
);

    localparam int unsigned IDX_W = $clog2(PORTS);

    logic [PORTS-1:0] grant_reg, grant_next;
    logic             grant_valid_reg, grant_valid_next;
    logic [IDX_W-1:0] grant_encoded_reg, grant_encoded_next;
    logic [PORTS-1:0] mask_reg, mask_next;

    logic [PORTS-1:0] req_masked;
    logic [PORTS-1:0] pick_src;
    logic [IDX_W-1:0] pick;
    logic             hold;

    // Priority encoder: the winning index of v in the configured priority direction.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [PORTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Next-state logic: either keep the current grant or arbitrate again.
    always_comb begin
        grant_next         = grant_reg;
        grant_valid_next   = grant_valid_reg;
        grant_encoded_next = grant_encoded_reg;
        mask_next          = mask_reg;

        req_masked = request & mask_reg;
        pick_src   = ((ARB_ROUND_ROBIN != 0) && (req_masked != '0)) ? req_masked : request;
        pick       = pick_idx(pick_src);

        hold = 1'b0;
        if (ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0)
                hold = grant_valid_reg && ((grant_reg & acknowledge) == '0);
            else
                hold = (grant_reg & request) != '0;
        end

        if (!hold) begin
            if (request != '0) begin
                grant_next         = PORTS'(1) << pick;
                grant_valid_next   = 1'b1;
                grant_encoded_next = pick;
                if (LSB_HIGH_PRIORITY != 0)
                    mask_next = {PORTS{1'b1}} << (int'(pick) + 1);
                else
                    mask_next = {PORTS{1'b1}} >> (int'(PORTS) - int'(pick));
            end else begin
                grant_next         = '0;
                grant_valid_next   = 1'b0;
                grant_encoded_next = '0;
            end
        end
    end

    // State registers. The asynchronous reset clears the grant and the mask history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_reg         <= '0;
            grant_valid_reg   <= 1'b0;
            grant_encoded_reg <= '0;
            mask_reg          <= '0;
        end else begin
            grant_reg         <= grant_next;
            grant_valid_reg   <= grant_valid_next;
            grant_encoded_reg <= grant_encoded_next;
            mask_reg          <= mask_next;
        end
    end

    assign grant         = grant_reg;
    assign grant_valid   = grant_valid_reg;
    assign grant_encoded = grant_encoded_reg;

endmodule

// File: tb/tb_iob_axi_crossbar_arb.sv
// Bench for iob_axi_crossbar_arb: four configurations driven by shared inputs.
// Each configuration is compared against a cyclic-search reference model.
module tb_iob_axi_crossbar_arb;

    localparam int NP  = 4;
    localparam int NC  = 4;

    logic          clk;
    logic          rst;
    logic [NP-1:0] req;
    logic [NP-1:0] ack;
    logic [NP-1:0] g  [NC];
    logic          gv [NC];
    logic [1:0]    ge [NC];

    int n_vec = 0;
    int n_err = 0;

    // Configuration table: rr, block, block_ack, lsb_high.
    int cfg_rr  [NC] = '{1, 0, 1, 1};
    int cfg_blk [NC] = '{1, 1, 1, 0};
    int cfg_ack [NC] = '{1, 1, 0, 1};
    int cfg_lsb [NC] = '{1, 0, 1, 0};

    // Model state: granted index (-1 means none) and the last index granted.
    int m_gnt  [NC];
    int m_last [NC];
    bit m_hist [NC];

    iob_axi_crossbar_arb #(.PORTS(NP), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1))
        u0 (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));
    iob_axi_crossbar_arb #(.PORTS(NP), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
        u1 (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));
    iob_axi_crossbar_arb #(.PORTS(NP), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1))
        u2 (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));
    iob_axi_crossbar_arb #(.PORTS(NP), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
        u3 (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Cyclic search starting just past the last winner, going in the priority direction.
    function automatic int pick(input int c, input logic [NP-1:0] r);
        int start;
        int idx;
        if (r == '0) return -1;
        if (cfg_lsb[c] != 0) begin
            start = (cfg_rr[c] != 0 && m_hist[c]) ? (m_last[c] + 1) % NP : 0;
            for (int i = 0; i < NP; i++) begin
                idx = (start + i) % NP;
                if (r[2'(idx)]) return idx;
            end
        end else begin
            start = (cfg_rr[c] != 0 && m_hist[c]) ? (m_last[c] + NP - 1) % NP : NP - 1;
            for (int i = 0; i < NP; i++) begin
                idx = (start - i + NP) % NP;
                if (r[2'(idx)]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_gnt[c]  = -1;
            m_last[c] = 0;
            m_hist[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [NP-1:0] r, input logic [NP-1:0] a);
        bit hold;
        int k;
        for (int c = 0; c < NC; c++) begin
            hold = 1'b0;
            if (cfg_blk[c] != 0 && m_gnt[c] >= 0) begin
                if (cfg_ack[c] != 0) hold = !a[2'(m_gnt[c])];
                else                 hold = r[2'(m_gnt[c])];
            end
            if (!hold) begin
                k = pick(c, r);
                m_gnt[c] = k;
                if (k >= 0) begin
                    m_last[c] = k;
                    m_hist[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string what);
        int eg;
        for (int c = 0; c < NC; c++) begin
            eg = (m_gnt[c] < 0) ? 0 : (1 << m_gnt[c]);
            check($sformatf("%s_c%0d_grant", what, c), int'(g[c]), eg);
            check($sformatf("%s_c%0d_valid", what, c), int'(gv[c]), (m_gnt[c] >= 0) ? 1 : 0);
            check($sformatf("%s_c%0d_enc", what, c), int'(ge[c]), (m_gnt[c] < 0) ? 0 : m_gnt[c]);
        end
    endtask

    task automatic check_zero(input string what);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_c%0d_grant", what, c), int'(g[c]), 0);
            check($sformatf("%s_c%0d_valid", what, c), int'(gv[c]), 0);
            check($sformatf("%s_c%0d_enc", what, c), int'(ge[c]), 0);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare just after it.
    task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] a, input string what);
        req = r;
        ack = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
        check_all(what);
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b1111;
        ack = 4'b0000;
        model_reset();

        // Reset asserted with requests active; outputs clear before any clock edge.
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        step(4'b0101, 4'b0000, "rst_rel");
        check("rst_rel_u0_grant", int'(g[0]), 4'b0001);
        check("rst_rel_u0_enc", int'(ge[0]), 0);

        // Round-robin rotation on u0.
        step(4'b1111, 4'b0001, "rr"); check("rr_u0_g1", int'(g[0]), 4'b0010);
        step(4'b1111, 4'b0010, "rr"); check("rr_u0_g2", int'(g[0]), 4'b0100);
        step(4'b1111, 4'b0100, "rr"); check("rr_u0_g3", int'(g[0]), 4'b1000);
        step(4'b1111, 4'b1000, "rr"); check("rr_u0_g0", int'(g[0]), 4'b0001);

        // Blocking with acknowledge: hold port 2 after its request drops.
        step(4'b0100, 4'b0001, "blk"); check("blk_u0_take2", int'(g[0]), 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b0000, "blk");
            check("blk_u0_hold", int'(g[0]), 4'b0100);
        end
        step(4'b1001, 4'b0100, "blk"); check("blk_u0_next", int'(g[0]), 4'b1000);

        // Fixed priority, msb wins: port 1 starves port 0.
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 4'b1111, "fix");
            check("fix_u1_starve", int'(g[1]), 4'b0010);
        end

        // Release on request drop; a stray acknowledge does nothing.
        step(4'b0010, 4'b0000, "nack"); check("nack_u2_take1", int'(g[2]), 4'b0010);
        step(4'b1000, 4'b0000, "nack"); check("nack_u2_move3", int'(g[2]), 4'b1000);
        step(4'b1000, 4'b0001, "nack"); check("nack_u2_stray", int'(g[2]), 4'b1000);

        // Async reset in the middle of a grant clears the grant and the mask history.
        step(4'b0100, 4'b1111, "mid"); check("mid_u0_take2", int'(g[0]), 4'b0100);
        #3 rst = 1'b1;
        #1 check_zero("mid_rst");
        model_reset();
        #1 rst = 1'b0;
        step(4'b1100, 4'b0000, "mid_rel"); check("mid_rel_u0", int'(g[0]), 4'b0100);

        // Randomized traffic, with an occasional reset between edges.
        for (int n = 0; n < 600; n++) begin
            logic [NP-1:0] r;
            logic [NP-1:0] a;
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                #1 check_zero("rnd_rst");
                model_reset();
                rst = 1'b0;
            end
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            step(r, a, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
